// File: rtl/sw_uart_pkg.sv
// Shared constants, state encoding and the baud divisor helper for the
// score-to-UART path.
package sw_uart_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        PREP    = 2'd2,
        SEND    = 2'd3
    } state_e;

    // Clock cycles per UART bit, rounded to nearest.
    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return (clk_hz + (baud / 32'd2)) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. o_ready is also high on the last stop-bit cycle so a
// send issued then chains the next frame with no idle gap.
module uart_tx_byte #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       CLOCK,
    input  logic       RST_N,
    input  logic [7:0] i_byte,
    input  logic       i_send,
    output logic       o_ready,
    output logic       o_txd
);

    localparam int unsigned DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BAUD_DIV - 1);

    logic             active_q, active_d;
    logic [3:0]       bit_q, bit_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [8:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             ready_s;

    assign ready_s = !active_q || ((bit_q == 4'd9) && (div_q == DIV_MAX));
    assign o_ready = ready_s;
    assign o_txd   = txd_q;

    // Frame sequencing: load on send, otherwise step bit timing.
    always_comb begin
        active_d = active_q;
        bit_d    = bit_q;
        div_d    = div_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        if (i_send && ready_s) begin
            active_d = 1'b1;
            bit_d    = 4'd0;
            div_d    = '0;
            shift_d  = {1'b1, i_byte};
            txd_d    = 1'b0;
        end else if (active_q) begin
            if (div_q == DIV_MAX) begin
                div_d = '0;
                if (bit_q == 4'd9) begin
                    active_d = 1'b0;
                    txd_d    = 1'b1;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    txd_d   = shift_q[0];
                    shift_d = {1'b1, shift_q[8:1]};
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end else begin
            txd_d = 1'b1;
        end
    end

    // Serialiser state registers.
    always_ff @(posedge CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            active_q <= 1'b0;
            bit_q    <= 4'd0;
            div_q    <= '0;
            shift_q  <= 9'h1FF;
            txd_q    <= 1'b1;
        end else begin
            active_q <= active_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
        end
    end

endmodule

// File: rtl/uart_score_tx.sv
// Converts an accepted binary score to decimal with double-dabble and sends
// it as "<digits>\r\n" over an 8N1 UART, suppressing leading zeros.
module uart_score_tx
    import sw_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned DATA_W = 18,
    parameter int unsigned DIGITS = 6
) (
    input  logic              CLOCK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_busy,
    output logic              o_txd,
    output logic              o_done,
    output logic              o_drop
);

    localparam int unsigned BAUD_DIV = baud_div(CLK_HZ, BAUD);
    localparam int unsigned BCD_W    = 4 * DIGITS;
    localparam int unsigned CNT_MAX  = (DATA_W > DIGITS + 2) ? DATA_W : DIGITS + 2;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned NDIG_W   = $clog2(DIGITS + 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NDIG_W-1:0] ndig_q, ndig_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;

    logic [BCD_W-1:0]  adj_s;
    logic [NDIG_W-1:0] lz_s;
    logic              found_s;
    logic [CNT_W-1:0]  ndig_ext_s;
    logic [CNT_W-1:0]  total_s;
    logic              send_s;
    logic [7:0]        byte_s;
    logic              tx_ready_s;

    // Add 3 to every BCD nibble that is 5 or more before the next shift.
    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = r[i*4 +: 4];
            end
        end
        return r;
    endfunction

    assign adj_s      = dabble_adj(bcd_q);
    assign ndig_ext_s = CNT_W'(ndig_q);
    assign total_s    = ndig_ext_s + CNT_W'(2);

    // Count leading zero digits; the least significant digit is always kept.
    always_comb begin
        lz_s    = '0;
        found_s = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (!found_s && (bcd_q[i*4 +: 4] == 4'd0)) begin
                lz_s = lz_s + NDIG_W'(1);
            end else begin
                found_s = 1'b1;
            end
        end
    end

    // Next-state logic: accept, convert, align digits, then sequence bytes.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ndig_d  = ndig_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        drop_d  = i_valid && ((state_q != IDLE) || done_q);
        send_s  = 1'b0;
        byte_s  = 8'h00;
        case (state_q)
            IDLE: begin
                if (i_valid && !done_q) begin
                    bin_d   = i_data;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONVERT;
                end else begin
                    state_d = IDLE;
                end
            end
            CONVERT: begin
                bcd_d = {adj_s[BCD_W-2:0], bin_q[DATA_W-1]};
                bin_d = {bin_q[DATA_W-2:0], 1'b0};
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    cnt_d   = '0;
                    state_d = PREP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PREP: begin
                bcd_d   = bcd_q << {lz_s, 2'b00};
                ndig_d  = NDIG_W'(DIGITS) - lz_s;
                state_d = SEND;
            end
            SEND: begin
                if (tx_ready_s) begin
                    if (cnt_q == total_s) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        send_s = 1'b1;
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q < ndig_ext_s) begin
                            byte_s = ASCII_ZERO + {4'h0, bcd_q[BCD_W-1 -: 4]};
                            bcd_d  = {bcd_q[BCD_W-5:0], 4'h0};
                        end else if (cnt_q == ndig_ext_s) begin
                            byte_s = ASCII_CR;
                        end else begin
                            byte_s = ASCII_LF;
                        end
                    end
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ndig_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ndig_q  <= ndig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .CLOCK   (CLOCK),
        .RST_N   (RST_N),
        .i_byte  (byte_s),
        .i_send  (send_s),
        .o_ready (tx_ready_s),
        .o_txd   (o_txd)
    );

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_drop = drop_q;

endmodule

// File: tb/tb_uart_score_tx.sv
// Directed plus random bench for uart_score_tx: a line monitor decodes 8N1
// frames and each message is compared against its decimal text.
module tb_uart_score_tx;

    localparam int unsigned DATA_W   = 18;
    localparam int unsigned BYTE_CYC = 100;

    logic              CLOCK = 1'b0;
    logic              RST_N = 1'b0;
    logic [DATA_W-1:0] i_data = '0;
    logic              i_valid = 1'b0;
    logic              o_busy, o_txd, o_done, o_drop;

    int n_checks = 0;
    int n_errors = 0;

    int unsigned cyc = 0;

    logic        mon_active = 1'b0;
    int unsigned mon_cnt = 0;
    int unsigned mon_start = 0;
    logic [7:0]  mon_sh = 8'h00;
    logic        mon_ok = 1'b0;
    logic [7:0]  rx_byte[$];
    logic        rx_ok[$];
    int unsigned rx_start[$];

    int unsigned done_cnt = 0;
    int unsigned done_cyc = 0;
    int unsigned drop_cnt = 0;

    uart_score_tx #(
        .CLK_HZ (1000),
        .BAUD   (100),
        .DATA_W (DATA_W),
        .DIGITS (6)
    ) dut (
        .CLOCK   (CLOCK),
        .RST_N   (RST_N),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_busy  (o_busy),
        .o_txd   (o_txd),
        .o_done  (o_done),
        .o_drop  (o_drop)
    );

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) cyc <= cyc + 1;

    // UART line monitor: samples each bit mid-way, records byte, framing and start cycle.
    always @(negedge CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            mon_active <= 1'b0;
            mon_cnt    <= 0;
        end else if (!mon_active) begin
            if (o_txd == 1'b0) begin
                mon_active <= 1'b1;
                mon_cnt    <= 1;
                mon_start  <= cyc;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt == 5) begin
                mon_ok <= (o_txd == 1'b0);
            end else if (mon_cnt >= 15 && mon_cnt <= 85 && (mon_cnt % 10) == 5) begin
                mon_sh <= {o_txd, mon_sh[7:1]};
            end else if (mon_cnt == 95) begin
                rx_byte.push_back(mon_sh);
                rx_ok.push_back(mon_ok && o_txd);
                rx_start.push_back(mon_start);
                mon_active <= 1'b0;
            end
        end
    end

    // Pulse counters for o_done / o_drop.
    always @(negedge CLOCK) begin
        if (o_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (o_drop) drop_cnt <= drop_cnt + 1;
    end

    task automatic tick();
        @(negedge CLOCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while ((o_busy || o_done) && waited < 2000) begin
            tick();
            waited++;
        end
        chk("idle_before_send", {31'd0, o_busy}, 32'd0);
    endtask

    // Send one score and compare the decoded line with its decimal text.
    task automatic send_and_check(input int unsigned value, input bit inject, input string tag);
        string       digits;
        int          len, base, waited;
        int unsigned d0, p0, e_cyc;
        logic [7:0]  exp_b;
        digits = $sformatf("%0d", value);
        len    = digits.len() + 2;
        wait_idle();
        base = rx_byte.size();
        d0   = done_cnt;
        p0   = drop_cnt;
        i_data  = DATA_W'(value);
        i_valid = 1'b1;
        tick();
        e_cyc   = cyc;
        i_valid = 1'b0;
        i_data  = DATA_W'($urandom_range(32'd262143, 32'd0));
        chk({tag, "_busy_after_accept"}, {31'd0, o_busy}, 32'd1);
        if (inject) begin
            repeat (150) tick();
            i_data  = DATA_W'(7);
            i_valid = 1'b1;
            tick();
            i_valid = 1'b0;
        end
        waited = 0;
        while (done_cnt == d0 && waited < len * BYTE_CYC + 200) begin
            tick();
            waited++;
        end
        chk({tag, "_done_pulses"}, done_cnt - d0, 32'd1);
        chk({tag, "_busy_low_at_done"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_drop_pulses"}, drop_cnt - p0, inject ? 32'd1 : 32'd0);
        chk({tag, "_byte_count"}, rx_byte.size() - base, len);
        for (int i = 0; i < len; i++) begin
            if (i < len - 2) exp_b = digits[i];
            else if (i == len - 2) exp_b = 8'h0D;
            else exp_b = 8'h0A;
            if (base + i < rx_byte.size()) begin
                chk($sformatf("%s_byte%0d", tag, i), {24'd0, rx_byte[base + i]}, {24'd0, exp_b});
                chk($sformatf("%s_frame%0d", tag, i), {31'd0, rx_ok[base + i]}, 32'd1);
                if (i > 0)
                    chk($sformatf("%s_gap%0d", tag, i),
                        rx_start[base + i] - rx_start[base + i - 1], BYTE_CYC);
            end
        end
        if (rx_byte.size() > base) begin
            chk({tag, "_first_start_latency"}, rx_start[base] - e_cyc, 32'd20);
            chk({tag, "_done_latency"}, done_cyc - rx_start[base], len * BYTE_CYC);
        end
    endtask

    initial begin
        int unsigned lows, base;
        // Reset state.
        RST_N = 1'b0;
        repeat (3) tick();
        chk("rst_txd", {31'd0, o_txd}, 32'd1);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_drop", {31'd0, o_drop}, 32'd0);
        RST_N = 1'b1;
        lows = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (o_txd !== 1'b1 || o_busy !== 1'b0) lows++;
        end
        chk("idle_line_high", lows, 32'd0);

        send_and_check(0, 1'b0, "zero");
        send_and_check(262143, 1'b0, "max");
        send_and_check(1205, 1'b1, "drop1205");
        send_and_check(7, 1'b0, "seven");
        for (int r = 0; r < 3; r++)
            send_and_check($urandom_range(32'd262143, 32'd0), 1'b0, $sformatf("rand%0d", r));

        // Reset in the middle of the second byte of "262143".
        wait_idle();
        base    = rx_byte.size();
        i_data  = DATA_W'(262143);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        repeat (170) tick();
        RST_N = 1'b0;
        #1;
        chk("midrst_txd", {31'd0, o_txd}, 32'd1);
        chk("midrst_busy", {31'd0, o_busy}, 32'd0);
        chk("midrst_done", {31'd0, o_done}, 32'd0);
        chk("midrst_drop", {31'd0, o_drop}, 32'd0);
        repeat (3) tick();
        chk("midrst_partial_count", rx_byte.size() - base, 32'd1);
        if (rx_byte.size() > base)
            chk("midrst_first_byte", {24'd0, rx_byte[base]}, 32'h32);
        RST_N = 1'b1;
        repeat (5) tick();
        send_and_check(42, 1'b0, "after_rst42");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
